// File: rtl/ddr_pkg.sv
// rtl/ddr_pkg.sv - shared screen geometry and arrow slot record
package ddr_pkg;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int COORD_W  = 10;

    typedef struct packed {
        logic               valid;
        logic [COORD_W-1:0] y;
    } slot_t;
endpackage

// File: rtl/lane_slot.sv
// rtl/lane_slot.sv - one in-flight arrow: step/expire/clear/load plus window and pixel tests
module lane_slot
    import ddr_pkg::*;
#(
    parameter int X_LEFT  = 0,
    parameter int ARROW_W = 32,
    parameter int ARROW_H = 32,
    parameter int Y_START = 0,
    parameter int Y_HIT   = 400,
    parameter int HIT_WIN = 16,
    parameter int Y_END   = 480
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               step,
    input  logic               load,
    input  logic               clear,
    input  logic [COORD_W-1:0] hc,
    input  logic [COORD_W-1:0] vc,
    output slot_t              slot,
    output logic               expire,
    output logic               in_window,
    output logic               covers_pixel
);
    localparam logic signed [10:0] WIN = 11'(HIT_WIN);
    localparam logic [10:0] XL = 11'(X_LEFT);
    localparam logic [10:0] XR = 11'(X_LEFT + ARROW_W);
    localparam logic [10:0] AH = 11'(ARROW_H);

    logic              at_end;
    logic signed [10:0] diff;
    logic [10:0]       hc_w, vc_w, y_w;

    assign at_end = (slot.y == COORD_W'(Y_END - 1));
    assign expire = slot.valid & step & at_end & ~clear;

    assign diff      = $signed({1'b0, slot.y}) - $signed(11'(Y_HIT));
    assign in_window = slot.valid && (diff >= -WIN) && (diff <= WIN);

    // 11-bit compares keep arrows near line 1023 from wrapping
    assign hc_w = {1'b0, hc};
    assign vc_w = {1'b0, vc};
    assign y_w  = {1'b0, slot.y};
    assign covers_pixel = slot.valid && (hc_w >= XL) && (hc_w < XR)
                          && (vc_w >= y_w) && (vc_w < y_w + AH);

    always_ff @(posedge CLK) begin
        if (reset || clear) begin
            slot <= '0;
        end else if (load) begin
            slot.valid <= 1'b1;
            slot.y     <= COORD_W'(Y_START);
        end else if (slot.valid && step) begin
            if (at_end) slot <= '0;
            else        slot.y <= slot.y + COORD_W'(1);
        end
    end
endmodule

// File: rtl/arrow_lane.sv
// rtl/arrow_lane.sv - per-lane falling-arrow tracker with hit judging and pixel coverage
module arrow_lane
    import ddr_pkg::*;
#(
    parameter int SLOTS   = 4,
    parameter int X_LEFT  = 0,
    parameter int ARROW_W = 32,
    parameter int ARROW_H = 32,
    parameter int Y_START = 0,
    parameter int Y_HIT   = 400,
    parameter int HIT_WIN = 16,
    parameter int Y_END   = 480
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               step,
    input  logic               spawn,
    input  logic               btn,
    input  logic [COORD_W-1:0] hc,
    input  logic [COORD_W-1:0] vc,
    output logic               pixel_on,
    output logic               hit,
    output logic               whiff,
    output logic               miss,
    output logic               spawn_drop,
    output logic [SLOTS-1:0]   active
);
    slot_t              slots [SLOTS];
    logic [SLOTS-1:0]   expire, in_win, covers, load, clear, at_start;
    logic               btn_q, press, spawn_ok, free_found, best_found;
    logic [SLOTS-1:0]   free_oh, best_oh;
    logic [COORD_W-1:0] best_y;

    for (genvar g = 0; g < SLOTS; g++) begin : g_slot
        lane_slot #(
            .X_LEFT(X_LEFT), .ARROW_W(ARROW_W), .ARROW_H(ARROW_H), .Y_START(Y_START),
            .Y_HIT(Y_HIT), .HIT_WIN(HIT_WIN), .Y_END(Y_END)
        ) u_slot (
            .CLK(CLK), .reset(reset), .step(step), .load(load[g]), .clear(clear[g]),
            .hc(hc), .vc(vc), .slot(slots[g]), .expire(expire[g]),
            .in_window(in_win[g]), .covers_pixel(covers[g])
        );
        assign active[g]   = slots[g].valid;
        assign at_start[g] = slots[g].valid && (slots[g].y == COORD_W'(Y_START));
    end

    // All decisions below look only at pre-edge slot state
    always_comb begin
        free_found = 1'b0;
        free_oh    = '0;
        best_found = 1'b0;
        best_oh    = '0;
        best_y     = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (!slots[i].valid && !free_found) begin
                free_found = 1'b1;
                free_oh    = '0;
                free_oh[i] = 1'b1;
            end
            if (in_win[i] && (!best_found || slots[i].y > best_y)) begin
                best_found = 1'b1;
                best_y     = slots[i].y;
                best_oh    = '0;
                best_oh[i] = 1'b1;
            end
        end
    end

    assign press    = btn & ~btn_q;
    assign spawn_ok = spawn && free_found && !(|at_start);
    assign load     = spawn_ok ? free_oh : '0;
    assign clear    = (press && best_found) ? best_oh : '0;

    always_ff @(posedge CLK) begin
        if (reset) begin
            btn_q      <= 1'b1;
            hit        <= 1'b0;
            whiff      <= 1'b0;
            miss       <= 1'b0;
            spawn_drop <= 1'b0;
            pixel_on   <= 1'b0;
        end else begin
            btn_q      <= btn;
            hit        <= press && best_found;
            whiff      <= press && !best_found;
            miss       <= |expire;
            spawn_drop <= spawn && !spawn_ok;
            pixel_on   <= |covers;
        end
    end
endmodule
